// File: rtl/jbi_sc_rpt_pkg.sv
// Shared defaults and helpers for the JBI <-> sctag/scbuf repeater pipeline.
package jbi_sc_rpt_pkg;

  localparam int JBI_DW_DEF       = 32;
  localparam int JBI_EW_DEF       = 7;
  localparam int JBI_NSTAGE_DEF   = 2;
  localparam int JBI_IQ_DEPTH_DEF = 16;

  // Counter must represent 0..depth inclusive.
  function automatic int credit_cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/jbi_sc_rpt_stage.sv
// One repeater flop stage; synchronous clear keeps flushed slots at zero.
module jbi_sc_rpt_stage #(
  parameter int W = 1
) (
  input  logic         rclk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge rclk) begin
    if (rst) q <= '0;
    else     q <= d;
  end

endmodule

// File: rtl/jbi_sc_rpt_pipe.sv
// Repeats JBI request, scbuf return and sctag control signals over NSTAGE
// flops, and tracks sctag IQ credits against undelayed requests.
module jbi_sc_rpt_pipe
  import jbi_sc_rpt_pkg::*;
#(
  parameter int DW       = JBI_DW_DEF,
  parameter int EW       = JBI_EW_DEF,
  parameter int NSTAGE   = JBI_NSTAGE_DEF,
  parameter int IQ_DEPTH = JBI_IQ_DEPTH_DEF
) (
  input  logic                                rclk,
  input  logic                                rst,
  input  logic [DW-1:0]                       jbi_sctag_req,
  input  logic                                jbi_sctag_req_vld,
  input  logic [DW-1:0]                       scbuf_jbi_data,
  input  logic [EW-1:0]                       jbi_scbuf_ecc,
  input  logic                                scbuf_jbi_ctag_vld,
  input  logic                                scbuf_jbi_ue_err,
  input  logic                                sctag_jbi_iq_dequeue,
  input  logic                                sctag_jbi_wib_dequeue,
  input  logic                                sctag_jbi_por_req,
  output logic [DW-1:0]                       jbi_sctag_req_d,
  output logic                                jbi_sctag_req_vld_d,
  output logic [DW-1:0]                       scbuf_jbi_data_d,
  output logic [EW-1:0]                       jbi_scbuf_ecc_d,
  output logic                                scbuf_jbi_ctag_vld_d,
  output logic                                scbuf_jbi_ue_err_d,
  output logic                                sctag_jbi_iq_dequeue_d,
  output logic                                sctag_jbi_wib_dequeue_d,
  output logic                                sctag_jbi_por_req_d,
  output logic [credit_cnt_w(IQ_DEPTH)-1:0]   jbi_iq_credit_cnt,
  output logic                                jbi_iq_credit_avail,
  output logic                                jbi_credit_err
);

  localparam int CW   = credit_cnt_w(IQ_DEPTH);
  localparam int RQ_W = DW + 1 + EW;
  localparam int RT_W = DW + 2;
  localparam int CT_W = 3;
  localparam logic [CW-1:0] CNT_FULL = CW'(IQ_DEPTH);

  if (NSTAGE < 1 || NSTAGE > 4) begin : g_bad_nstage
    $error("jbi_sc_rpt_pipe: NSTAGE must be in 1..4");
  end
  if (IQ_DEPTH < 1 || IQ_DEPTH > 64) begin : g_bad_iq_depth
    $error("jbi_sc_rpt_pipe: IQ_DEPTH must be in 1..64");
  end

  // Index 0 is the live input; index NSTAGE is the repeated output.
  logic [NSTAGE:0][RQ_W-1:0] rq_pipe;
  logic [NSTAGE:0][RT_W-1:0] rt_pipe;
  logic [NSTAGE:0][CT_W-1:0] ct_pipe;

  assign rq_pipe[0] = {jbi_sctag_req, jbi_sctag_req_vld, jbi_scbuf_ecc};
  assign rt_pipe[0] = {scbuf_jbi_data, scbuf_jbi_ctag_vld, scbuf_jbi_ue_err};
  assign ct_pipe[0] = {sctag_jbi_iq_dequeue, sctag_jbi_wib_dequeue, sctag_jbi_por_req};

  for (genvar i = 0; i < NSTAGE; i++) begin : g_stage
    jbi_sc_rpt_stage #(.W(RQ_W)) u_rq (
      .rclk (rclk),
      .rst  (rst),
      .d    (rq_pipe[i]),
      .q    (rq_pipe[i+1])
    );
    jbi_sc_rpt_stage #(.W(RT_W)) u_rt (
      .rclk (rclk),
      .rst  (rst),
      .d    (rt_pipe[i]),
      .q    (rt_pipe[i+1])
    );
    jbi_sc_rpt_stage #(.W(CT_W)) u_ct (
      .rclk (rclk),
      .rst  (rst),
      .d    (ct_pipe[i]),
      .q    (ct_pipe[i+1])
    );
  end

  assign {jbi_sctag_req_d, jbi_sctag_req_vld_d, jbi_scbuf_ecc_d} = rq_pipe[NSTAGE];
  assign {scbuf_jbi_data_d, scbuf_jbi_ctag_vld_d, scbuf_jbi_ue_err_d} = rt_pipe[NSTAGE];
  assign {sctag_jbi_iq_dequeue_d, sctag_jbi_wib_dequeue_d, sctag_jbi_por_req_d} = ct_pipe[NSTAGE];

  // Credits leave when a request is issued and return when the repeated
  // dequeue arrives; a coincident pair cancels.
  logic [CW-1:0] credit_cnt;
  logic          credit_err;

  always_ff @(posedge rclk) begin
    if (rst || sctag_jbi_por_req_d) begin
      credit_cnt <= CNT_FULL;
      credit_err <= 1'b0;
    end else if (jbi_sctag_req_vld && !sctag_jbi_iq_dequeue_d) begin
      if (credit_cnt == '0) credit_err <= 1'b1;
      else                  credit_cnt <= credit_cnt - CW'(1);
    end else if (!jbi_sctag_req_vld && sctag_jbi_iq_dequeue_d) begin
      if (credit_cnt == CNT_FULL) credit_err <= 1'b1;
      else                        credit_cnt <= credit_cnt + CW'(1);
    end
  end

  assign jbi_iq_credit_cnt   = credit_cnt;
  assign jbi_iq_credit_avail = (credit_cnt != '0);
  assign jbi_credit_err      = credit_err;

endmodule

// File: tb/tb_jbi_sc_rpt_pipe.sv
// Bench for jbi_sc_rpt_pipe: a 3-stage/4-credit instance and a 1-stage/64-bit
// instance share stimulus and are checked against an input-history model.
module tb_jbi_sc_rpt_pipe;

  localparam int NA = 3, DA = 4, NB = 1, DB = 16, MAXC = 1024;

  logic        rclk = 1'b0;
  logic        rst;
  logic [31:0] req_a, data_a;
  logic [63:0] req_b, data_b;
  logic [6:0]  ecc;
  logic        vld, ctag, ue, iq, wib, por;

  logic [31:0] a_req_d, a_data_d;
  logic [6:0]  a_ecc_d;
  logic        a_vld_d, a_ctag_d, a_ue_d, a_iq_d, a_wib_d, a_por_d;
  logic [2:0]  a_cnt;
  logic        a_avail, a_err;

  logic [63:0] b_req_d, b_data_d;
  logic [6:0]  b_ecc_d;
  logic        b_vld_d, b_ctag_d, b_ue_d, b_iq_d, b_wib_d, b_por_d;
  logic [4:0]  b_cnt;
  logic        b_avail, b_err;

  always #5 rclk = ~rclk;

  jbi_sc_rpt_pipe #(.DW(32), .EW(7), .NSTAGE(NA), .IQ_DEPTH(DA)) u_dut_a (
    .rclk(rclk), .rst(rst),
    .jbi_sctag_req(req_a), .jbi_sctag_req_vld(vld), .scbuf_jbi_data(data_a),
    .jbi_scbuf_ecc(ecc), .scbuf_jbi_ctag_vld(ctag), .scbuf_jbi_ue_err(ue),
    .sctag_jbi_iq_dequeue(iq), .sctag_jbi_wib_dequeue(wib), .sctag_jbi_por_req(por),
    .jbi_sctag_req_d(a_req_d), .jbi_sctag_req_vld_d(a_vld_d), .scbuf_jbi_data_d(a_data_d),
    .jbi_scbuf_ecc_d(a_ecc_d), .scbuf_jbi_ctag_vld_d(a_ctag_d), .scbuf_jbi_ue_err_d(a_ue_d),
    .sctag_jbi_iq_dequeue_d(a_iq_d), .sctag_jbi_wib_dequeue_d(a_wib_d),
    .sctag_jbi_por_req_d(a_por_d),
    .jbi_iq_credit_cnt(a_cnt), .jbi_iq_credit_avail(a_avail), .jbi_credit_err(a_err)
  );

  jbi_sc_rpt_pipe #(.DW(64), .EW(7), .NSTAGE(NB), .IQ_DEPTH(DB)) u_dut_b (
    .rclk(rclk), .rst(rst),
    .jbi_sctag_req(req_b), .jbi_sctag_req_vld(vld), .scbuf_jbi_data(data_b),
    .jbi_scbuf_ecc(ecc), .scbuf_jbi_ctag_vld(ctag), .scbuf_jbi_ue_err(ue),
    .sctag_jbi_iq_dequeue(iq), .sctag_jbi_wib_dequeue(wib), .sctag_jbi_por_req(por),
    .jbi_sctag_req_d(b_req_d), .jbi_sctag_req_vld_d(b_vld_d), .scbuf_jbi_data_d(b_data_d),
    .jbi_scbuf_ecc_d(b_ecc_d), .scbuf_jbi_ctag_vld_d(b_ctag_d), .scbuf_jbi_ue_err_d(b_ue_d),
    .sctag_jbi_iq_dequeue_d(b_iq_d), .sctag_jbi_wib_dequeue_d(b_wib_d),
    .sctag_jbi_por_req_d(b_por_d),
    .jbi_iq_credit_cnt(b_cnt), .jbi_iq_credit_avail(b_avail), .jbi_credit_err(b_err)
  );

  // Input history, one entry per rising edge
  logic [31:0] h_req_a[MAXC], h_data_a[MAXC];
  logic [63:0] h_req_b[MAXC], h_data_b[MAXC];
  logic [6:0]  h_ecc[MAXC];
  bit          h_vld[MAXC], h_ctag[MAXC], h_ue[MAXC], h_iq[MAXC], h_wib[MAXC];
  bit          h_por[MAXC], h_rst[MAXC];
  int          nedge = 0;

  int compared = 0, mismatched = 0;
  int m_cnt_a = DA, m_cnt_b = DB;
  bit m_err_a = 1'b0, m_err_b = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      if (mismatched <= 40)
        $display("FAIL %s @%0t: got %0h, want %0h", name, $time, act, exp);
    end
  endtask

  // Which edge's inputs are visible at the output after edge 'last' of an
  // n-deep repeater, or -1 if nothing survived (too early, or reset since).
  function automatic int src_of(input int last, input int n);
    int s;
    s = last - n + 1;
    if (s < 0) return -1;
    for (int j = s; j <= last; j++) if (h_rst[j]) return -1;
    return s;
  endfunction

  task automatic credit_step(input int n, input int d, input int last,
                             input int cnt_i, input bit err_i,
                             output int cnt_o, output bit err_o);
    int s, t;
    bit deq_d, por_d;
    s = (last >= 1) ? src_of(last - 1, n) : -1;
    deq_d = (s >= 0) ? h_iq[s] : 1'b0;
    por_d = (s >= 0) ? h_por[s] : 1'b0;
    cnt_o = cnt_i;
    err_o = err_i;
    if (h_rst[last] || por_d) begin
      cnt_o = d;
      err_o = 1'b0;
    end else begin
      t = cnt_i - int'(h_vld[last]) + int'(deq_d);
      if (t < 0) begin t = 0; err_o = 1'b1; end
      else if (t > d) begin t = d; err_o = 1'b1; end
      cnt_o = t;
    end
  endtask

  initial begin
    forever begin
      @(posedge rclk);
      if (nedge < MAXC) begin
        h_req_a[nedge] = req_a;  h_data_a[nedge] = data_a;
        h_req_b[nedge] = req_b;  h_data_b[nedge] = data_b;
        h_ecc[nedge] = ecc;      h_vld[nedge] = vld;
        h_ctag[nedge] = ctag;    h_ue[nedge] = ue;
        h_iq[nedge] = iq;        h_wib[nedge] = wib;
        h_por[nedge] = por;      h_rst[nedge] = rst;
      end
      nedge++;
    end
  end

  initial begin
    int l, s;
    forever begin
      @(negedge rclk);
      if (nedge >= 1 && nedge <= MAXC) begin
        l = nedge - 1;
        credit_step(NA, DA, l, m_cnt_a, m_err_a, m_cnt_a, m_err_a);
        credit_step(NB, DB, l, m_cnt_b, m_err_b, m_cnt_b, m_err_b);

        s = src_of(l, NA);
        chk("a_req_d",  a_req_d,  (s >= 0) ? h_req_a[s]  : 32'h0);
        chk("a_vld_d",  a_vld_d,  (s >= 0) ? h_vld[s]    : 1'b0);
        chk("a_data_d", a_data_d, (s >= 0) ? h_data_a[s] : 32'h0);
        chk("a_ecc_d",  a_ecc_d,  (s >= 0) ? h_ecc[s]    : 7'h0);
        chk("a_ctag_d", a_ctag_d, (s >= 0) ? h_ctag[s]   : 1'b0);
        chk("a_ue_d",   a_ue_d,   (s >= 0) ? h_ue[s]     : 1'b0);
        chk("a_iq_d",   a_iq_d,   (s >= 0) ? h_iq[s]     : 1'b0);
        chk("a_wib_d",  a_wib_d,  (s >= 0) ? h_wib[s]    : 1'b0);
        chk("a_por_d",  a_por_d,  (s >= 0) ? h_por[s]    : 1'b0);
        chk("a_cnt",    a_cnt,    m_cnt_a);
        chk("a_avail",  a_avail,  m_cnt_a != 0);
        chk("a_err",    a_err,    m_err_a);

        s = src_of(l, NB);
        chk("b_req_d",  b_req_d,  (s >= 0) ? h_req_b[s]  : 64'h0);
        chk("b_vld_d",  b_vld_d,  (s >= 0) ? h_vld[s]    : 1'b0);
        chk("b_data_d", b_data_d, (s >= 0) ? h_data_b[s] : 64'h0);
        chk("b_ecc_d",  b_ecc_d,  (s >= 0) ? h_ecc[s]    : 7'h0);
        chk("b_ctag_d", b_ctag_d, (s >= 0) ? h_ctag[s]   : 1'b0);
        chk("b_ue_d",   b_ue_d,   (s >= 0) ? h_ue[s]     : 1'b0);
        chk("b_iq_d",   b_iq_d,   (s >= 0) ? h_iq[s]     : 1'b0);
        chk("b_wib_d",  b_wib_d,  (s >= 0) ? h_wib[s]    : 1'b0);
        chk("b_por_d",  b_por_d,  (s >= 0) ? h_por[s]    : 1'b0);
        chk("b_cnt",    b_cnt,    m_cnt_b);
        chk("b_avail",  b_avail,  m_cnt_b != 0);
        chk("b_err",    b_err,    m_err_b);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge rclk);
      #2;
    end
  endtask

  task automatic clr();
    req_a = '0; data_a = '0; req_b = '0; data_b = '0; ecc = '0;
    vld = 1'b0; ctag = 1'b0; ue = 1'b0; iq = 1'b0; wib = 1'b0; por = 1'b0;
  endtask

  task automatic rnd();
    req_a  = $urandom;
    data_a = $urandom;
    req_b  = {$urandom, $urandom};
    data_b = {$urandom, $urandom};
    ecc    = 7'($urandom);
    vld    = 1'($urandom);
    ctag   = 1'($urandom);
    ue     = 1'($urandom);
    iq     = 1'($urandom);
    wib    = 1'($urandom);
    por    = 1'b0;
  endtask

  initial begin
    clr();
    rst = 1'b1;
    step(2);
    chk("rst_a_cnt",   a_cnt,   3'd4);
    chk("rst_a_err",   a_err,   1'b0);
    chk("rst_a_avail", a_avail, 1'b1);
    chk("rst_a_vld_d", a_vld_d, 1'b0);
    chk("rst_b_cnt",   b_cnt,   5'd16);
    rst = 1'b0;

    // Continuous random traffic with two marked words for latency
    rnd();
    req_a = 32'hA5A5_0001;
    req_b = 64'h0123_4567_89AB_CDEF;
    step(1);
    chk("b_lat1_req", b_req_d, 64'h0123_4567_89AB_CDEF);
    rnd(); step(1);
    rnd(); step(1);
    chk("a_lat3_req", a_req_d, 32'hA5A5_0001);
    for (int i = 0; i < 20; i++) begin
      rnd();
      step(1);
    end
    clr();
    step(NA + 1);
    por = 1'b1; step(1); por = 1'b0; step(NA);
    chk("por0_cnt", a_cnt, 3'd4);
    chk("por0_err", a_err, 1'b0);

    // Drain all four credits, then underflow
    vld = 1'b1;
    step(1); chk("uf_cnt3", a_cnt, 3'd3);
    step(1); chk("uf_cnt2", a_cnt, 3'd2);
    step(1); chk("uf_cnt1", a_cnt, 3'd1);
    step(1); chk("uf_cnt0", a_cnt, 3'd0);
    chk("uf_avail0", a_avail, 1'b0);
    chk("uf_err_pre", a_err, 1'b0);
    step(1);
    chk("uf_hold0", a_cnt, 3'd0);
    chk("uf_avail", a_avail, 1'b0);
    chk("uf_err", a_err, 1'b1);
    vld = 1'b0;

    // Coincident request and repeated dequeue at count 2
    por = 1'b1; step(1); por = 1'b0; step(NA);
    chk("por1_cnt", a_cnt, 3'd4);
    chk("por1_err", a_err, 1'b0);
    vld = 1'b1; step(2); vld = 1'b0;
    chk("same_pre", a_cnt, 3'd2);
    iq = 1'b1; step(1); iq = 1'b0; step(NA - 1);
    chk("same_wait", a_cnt, 3'd2);
    vld = 1'b1; step(1); vld = 1'b0;
    chk("same_cnt", a_cnt, 3'd2);
    chk("same_err", a_err, 1'b0);
    step(1);
    chk("same_after", a_cnt, 3'd2);

    // Refill to full, overflow, then power-on-reset request
    iq = 1'b1; step(3); iq = 1'b0; step(NA);
    chk("of_cnt", a_cnt, 3'd4);
    chk("of_err", a_err, 1'b1);
    por = 1'b1; step(1); por = 1'b0; step(NA - 1);
    chk("por2_early_err", a_err, 1'b1);
    step(1);
    chk("por2_cnt", a_cnt, 3'd4);
    chk("por2_err", a_err, 1'b0);

    // Reset while two requests are still in the repeater
    vld = 1'b1; step(2); vld = 1'b0;
    chk("flush_pre_cnt", a_cnt, 3'd2);
    rst = 1'b1; step(1); rst = 1'b0;
    chk("flush_cnt", a_cnt, 3'd4);
    for (int i = 0; i < NA + 1; i++) begin
      chk("flush_vld_d", a_vld_d, 1'b0);
      step(1);
    end
    chk("flush_cnt_end", a_cnt, 3'd4);

    // Full-width data on the single-stage instance
    for (int i = 0; i < 10; i++) begin
      rnd();
      step(1);
    end
    req_b  = 64'hDEAD_BEEF_0123_4567;
    data_b = 64'hFEDC_BA98_7654_3210;
    step(1);
    chk("b_wide_req",  b_req_d,  64'hDEAD_BEEF_0123_4567);
    chk("b_wide_data", b_data_d, 64'hFEDC_BA98_7654_3210);
    clr();
    step(NA + 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
